// File: rtl/block_processor.sv
`default_nettype none
// ============================================================================
// Module   : block_processor
// Purpose  : Computes one element C[row][col] = sum_k A[row][k] * B[k][col]
//            of a matrix product. Operands are fetched over a shared,
//            grant-arbitrated 32-bit memory bus, and the result is written
//            back to the C region of memory.
// Options  : BLOCK_PROCESSOR_SATURATE_EN - when defined, the product and the
//            accumulation saturate to 0x7FFFFFFF / 0x80000000. When it is not
//            defined, both wrap modulo 2^32.
// Revision : 1.0 - initial release
// ============================================================================
module block_processor #(
  parameter int index_width     = 8,
  parameter int greek_size      = 8,
  parameter int memory_size_log = 10
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic                       i_Indexes_Ready,
  input  logic [index_width-1:0]     i_Row_Index,
  input  logic [index_width-1:0]     i_Column_Index,
  input  logic [greek_size-1:0]      i_Gamma,
  input  logic [greek_size-1:0]      i_Lambda,
  input  logic [greek_size-1:0]      i_Mu,
  output logic                       o_Indexes_Received,
  output logic                       o_Result_Ready,
  output logic                       o_Grant_Request,
  input  logic                       i_Grant,
  output logic [memory_size_log-1:0] o_Memory_Address,
  output logic                       o_Write_Enable,
  inout  wire  [31:0]                io_Memory_Data
);

  localparam int AW = memory_size_log;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RD_A0 = 3'd2,
    S_RD_A1 = 3'd3,
    S_RD_B0 = 3'd4,
    S_RD_B1 = 3'd5,
    S_MAC   = 3'd6,
    S_WRITE = 3'd7
  } state_t;

  state_t                r_state;
  logic                  r_spare_pend;
  logic                  r_idx_rcvd;
  logic                  r_result;
  logic                  r_req;
  logic                  r_we;
  logic [AW-1:0]         r_addr;
  logic [31:0]           r_wdata;
  logic [AW-1:0]         r_a_ptr;
  logic [AW-1:0]         r_b_ptr;
  logic [AW-1:0]         r_c_addr;
  logic [greek_size-1:0] r_mu;
  logic [greek_size-1:0] r_lambda;
  logic [greek_size-1:0] r_k;
  logic [31:0]           r_acc;
  logic [31:0]           r_a;
  logic [31:0]           r_b;

  // Address-map arithmetic. It is evaluated from the live inputs and consumed
  // only at the accepting edge, so the geometry is frozen from then on. All
  // sums are truncated to the bus width, which gives the wrap behaviour.
  logic [AW-1:0] w_b_base;
  logic [AW-1:0] w_c_base;
  logic [AW-1:0] w_a_start;
  logic [AW-1:0] w_b_start;
  logic [AW-1:0] w_c_addr;
  logic          w_spare;

  assign w_b_base  = AW'(32'd2 + 32'(i_Gamma) * 32'(i_Mu));
  assign w_c_base  = AW'(32'(w_b_base) + 32'(i_Mu) * 32'(i_Lambda));
  assign w_a_start = AW'(32'd2 + 32'(i_Row_Index) * 32'(i_Mu));
  assign w_b_start = AW'(32'(w_b_base) + 32'(i_Column_Index));
  assign w_c_addr  = AW'(32'(w_c_base) + 32'(i_Row_Index) * 32'(i_Lambda)
                         + 32'(i_Column_Index));
  assign w_spare   = (32'(i_Row_Index) >= 32'(i_Gamma)) ||
                     (32'(i_Column_Index) >= 32'(i_Lambda));

  // Inner-loop bookkeeping. The counter is widened by one bit so that
  // k + 1 == 2^greek_size cannot overflow.
  logic [greek_size:0] w_k_next;
  logic                w_more;

  assign w_k_next = {1'b0, r_k} + (greek_size + 1)'(1);
  assign w_more   = w_k_next < {1'b0, r_mu};

  logic [31:0] w_acc_next;

`ifdef BLOCK_PROCESSOR_SATURATE_EN
  logic signed [63:0] w_full;
  logic        [31:0] w_prod;
  logic signed [32:0] w_sum;

  assign w_full = $signed(r_a) * $signed(r_b);
  assign w_sum  = {w_prod[31], w_prod} + {r_acc[31], r_acc};

  // Clamp the full-precision product, then clamp the accumulation.
  always_comb begin
    w_prod     = w_full[31:0];
    w_acc_next = w_sum[31:0];
    if (w_full[63:31] != {33{w_full[63]}}) begin
      w_prod = w_full[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    if (w_sum[32] != w_sum[31]) begin
      w_acc_next = w_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end
`else
  // The low 32 bits of the product are added modulo 2^32.
  // Two's-complement operands need no special handling here.
  always_comb begin
    w_acc_next = r_acc + r_a * r_b;
  end
`endif

  // Control FSM and all registered outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state      <= S_IDLE;
      r_spare_pend <= 1'b0;
      r_idx_rcvd   <= 1'b0;
      r_result     <= 1'b0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_a_ptr      <= '0;
      r_b_ptr      <= '0;
      r_c_addr     <= '0;
      r_mu         <= '0;
      r_lambda     <= '0;
      r_k          <= '0;
      r_acc        <= '0;
      r_a          <= '0;
      r_b          <= '0;
    end else begin
      r_idx_rcvd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_spare_pend) begin
            // A spare processor has nothing to compute and reports completion at once.
            r_spare_pend <= 1'b0;
            r_result     <= 1'b1;
          end else if (i_Indexes_Ready) begin
            r_idx_rcvd <= 1'b1;
            r_result   <= 1'b0;
            r_acc      <= '0;
            r_k        <= '0;
            r_mu       <= i_Mu;
            r_lambda   <= i_Lambda;
            r_a_ptr    <= w_a_start;
            r_b_ptr    <= w_b_start;
            r_c_addr   <= w_c_addr;
            if (w_spare) begin
              r_spare_pend <= 1'b1;
            end else begin
              r_req   <= 1'b1;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (i_Grant) begin
            if (r_mu == '0) begin
              r_addr  <= r_c_addr;
              r_wdata <= '0;
              r_we    <= 1'b1;
              r_state <= S_WRITE;
            end else begin
              r_addr  <= r_a_ptr;
              r_state <= S_RD_A0;
            end
          end
        end
        // In the read states, a missing grant freezes the FSM with the
        // address held. The access then completes once the grant is back.
        S_RD_A0: if (i_Grant) r_state <= S_RD_A1;
        S_RD_A1: begin
          if (i_Grant) begin
            r_a     <= io_Memory_Data;
            r_addr  <= r_b_ptr;
            r_state <= S_RD_B0;
          end
        end
        S_RD_B0: if (i_Grant) r_state <= S_RD_B1;
        S_RD_B1: begin
          if (i_Grant) begin
            r_b     <= io_Memory_Data;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc   <= w_acc_next;
          r_k     <= w_k_next[greek_size-1:0];
          r_a_ptr <= r_a_ptr + AW'(1);
          r_b_ptr <= r_b_ptr + AW'(r_lambda);
          if (w_more) begin
            r_addr  <= r_a_ptr + AW'(1);
            r_state <= S_RD_A0;
          end else begin
            r_addr  <= r_c_addr;
            r_wdata <= w_acc_next;
            r_we    <= 1'b1;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          // The write strobe is held until a cycle that has the grant.
          if (i_Grant) begin
            r_we     <= 1'b0;
            r_req    <= 1'b0;
            r_result <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_Indexes_Received = r_idx_rcvd;
  assign o_Result_Ready     = r_result;
  assign o_Grant_Request    = r_req;
  assign o_Memory_Address   = r_addr;
  assign o_Write_Enable     = r_we;
  assign io_Memory_Data     = r_we ? r_wdata : 32'bz;

endmodule
`default_nettype wire
